// File: rtl/alien_hit_resolver.sv
// alien_hit_resolver
//   Converts a bullet/alien pixel overlap seen during the VGA scan into a
//   kill request for one alien of the formation. The hit coordinate is taken
//   relative to the formation origin. It is then reduced to (row, col) by
//   repeated subtraction of the alien pitch, which does one step per cycle.
//   The target is checked against the sprite box and the alive matrix. A
//   valid/ready kill request is then held until it is accepted. On
//   acceptance the score is updated and the player bullet is told to despawn.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   scan_x, scan_y   current scan position
//   frame_start      one-cycle pulse per frame, re-arms the one-kill-per-frame lock
//   alien_pixel      formation pixel active at the scan position
//   bullet_pixel     player bullet pixel active at the scan position
//   formation_x/y    origin of alien [0][0], stable within a frame
//   alive_matrix     alive flags, bit row*NUM_COLUMNS+col
//   kill_valid/ready kill request handshake, with kill_row/kill_col
//   bullet_consume   one-cycle pulse after an accepted kill
//   score            saturating score
//   busy             resolver is not idle
module alien_hit_resolver #(
  parameter int NUM_ROWS        = 2,
  parameter int NUM_COLUMNS     = 4,
  parameter int ALIEN_SPACING_X = 40,
  parameter int ALIEN_SPACING_Y = 40,
  parameter int ALIEN_WIDTH     = 32,
  parameter int ALIEN_HEIGHT    = 16,
  parameter int ROW_POINTS      = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [15:0]                     scan_x,
  input  logic [15:0]                     scan_y,
  input  logic                            frame_start,
  input  logic                            alien_pixel,
  input  logic                            bullet_pixel,
  input  logic [15:0]                     formation_x,
  input  logic [15:0]                     formation_y,
  input  logic [NUM_ROWS*NUM_COLUMNS-1:0] alive_matrix,
  output logic                            kill_valid,
  input  logic                            kill_ready,
  output logic [15:0]                     kill_row,
  output logic [15:0]                     kill_col,
  output logic                            bullet_consume,
  output logic [15:0]                     score,
  output logic                            busy
);

  typedef enum logic [2:0] {IDLE, DIV_X, DIV_Y, CHECK, REQ} state_t;

  localparam logic [16:0] SPACING_X = 17'(ALIEN_SPACING_X);
  localparam logic [16:0] SPACING_Y = 17'(ALIEN_SPACING_Y);
  localparam logic [16:0] WIDTH     = 17'(ALIEN_WIDTH);
  localparam logic [16:0] HEIGHT    = 17'(ALIEN_HEIGHT);
  localparam logic [15:0] LAST_COL  = 16'(NUM_COLUMNS - 1);
  localparam logic [15:0] LAST_ROW  = 16'(NUM_ROWS - 1);

  state_t      state_reg;
  logic [16:0] dx_reg;
  logic [16:0] dy_reg;
  logic [15:0] col_reg;
  logic [15:0] row_reg;
  logic        hit_this_frame_reg;

  // Bit 16 of these differences is the borrow: scan left of / above origin.
  logic [16:0] dx_start;
  logic [16:0] dy_start;
  logic        hit;
  assign dx_start = {1'b0, scan_x} - {1'b0, formation_x};
  assign dy_start = {1'b0, scan_y} - {1'b0, formation_y};
  assign hit      = alien_pixel & bullet_pixel & ~hit_this_frame_reg;

  // Alive flag of the currently resolved cell.
  logic [NUM_ROWS*NUM_COLUMNS-1:0] cell_sel;
  logic                            alive_sel;
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROWS * NUM_COLUMNS; gi++) begin : g_cell
      assign cell_sel[gi] = alive_matrix[gi]
                            && (row_reg == 16'(gi / NUM_COLUMNS))
                            && (col_reg == 16'(gi % NUM_COLUMNS));
    end
  endgenerate
  assign alive_sel = |cell_sel;

  // Row r is worth ROW_POINTS*(NUM_ROWS-r): front rows score less.
  logic [15:0] points;
  always_comb begin
    points = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (kill_row == 16'(r)) points = 16'(ROW_POINTS * (NUM_ROWS - r));
    end
  end

  logic [16:0] score_sum;
  assign score_sum = {1'b0, score} + {1'b0, points};

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      dx_reg             <= '0;
      dy_reg             <= '0;
      col_reg            <= '0;
      row_reg            <= '0;
      hit_this_frame_reg <= 1'b0;
      kill_valid         <= 1'b0;
      kill_row           <= '0;
      kill_col           <= '0;
      bullet_consume     <= 1'b0;
      score              <= '0;
    end else begin
      bullet_consume <= 1'b0;
      if (frame_start) hit_this_frame_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (hit && !dx_start[16] && !dy_start[16]) begin
            dx_reg    <= dx_start;
            dy_reg    <= dy_start;
            col_reg   <= '0;
            row_reg   <= '0;
            state_reg <= DIV_X;
          end
        end

        DIV_X: begin
          if (dx_reg >= SPACING_X) begin
            // Another step would land right of the last column.
            if (col_reg == LAST_COL) begin
              state_reg <= IDLE;
            end else begin
              dx_reg  <= dx_reg - SPACING_X;
              col_reg <= col_reg + 16'd1;
            end
          end else begin
            state_reg <= DIV_Y;
          end
        end

        DIV_Y: begin
          if (dy_reg >= SPACING_Y) begin
            if (row_reg == LAST_ROW) begin
              state_reg <= IDLE;
            end else begin
              dy_reg  <= dy_reg - SPACING_Y;
              row_reg <= row_reg + 16'd1;
            end
          end else begin
            state_reg <= CHECK;
          end
        end

        CHECK: begin
          // Remainders outside the sprite box are gap pixels between aliens.
          if (dx_reg < WIDTH && dy_reg < HEIGHT && alive_sel) begin
            kill_row   <= row_reg;
            kill_col   <= col_reg;
            kill_valid <= 1'b1;
            state_reg  <= REQ;
          end else begin
            state_reg <= IDLE;
          end
        end

        REQ: begin
          if (kill_valid && kill_ready) begin
            score              <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            kill_valid         <= 1'b0;
            bullet_consume     <= 1'b1;
            // Overrides a coincident frame_start clear above.
            hit_this_frame_reg <= 1'b1;
            state_reg          <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alien_hit_resolver.sv
module tb_alien_hit_resolver;

  localparam int NR = 2;
  localparam int NC = 4;
  localparam int SPX = 40;
  localparam int SPY = 40;
  localparam int AW = 32;
  localparam int AH = 16;
  localparam int RP = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] scan_x, scan_y, formation_x, formation_y;
  logic        frame_start, alien_pixel, bullet_pixel, kill_ready;
  logic [7:0]  alive_matrix;
  logic        kill_valid, bullet_consume, busy;
  logic [15:0] kill_row, kill_col, score;

  int checks_total = 0;
  int errors = 0;

  // Reference state
  int  score_m = 0;
  bit  hit_frame_m = 1'b0;

  always #5 clk = ~clk;

  alien_hit_resolver dut (
    .clk(clk), .rst(rst), .scan_x(scan_x), .scan_y(scan_y),
    .frame_start(frame_start), .alien_pixel(alien_pixel),
    .bullet_pixel(bullet_pixel), .formation_x(formation_x),
    .formation_y(formation_y), .alive_matrix(alive_matrix),
    .kill_valid(kill_valid), .kill_ready(kill_ready), .kill_row(kill_row),
    .kill_col(kill_col), .bullet_consume(bullet_consume), .score(score),
    .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    hit_frame_m = 1'b0;
  endtask

  // Reference: plain division of the offset by the pitch.
  task automatic predict(input int x, input int y, output bit kill,
                         output int r, output int c);
    int dx, dy;
    dx = x - int'(formation_x);
    dy = y - int'(formation_y);
    kill = 1'b0;
    r = 0;
    c = 0;
    if (hit_frame_m || dx < 0 || dy < 0) return;
    c = dx / SPX;
    r = dy / SPY;
    if (c >= NC || r >= NR) return;
    if ((dx % SPX) >= AW || (dy % SPY) >= AH) return;
    if (!alive_matrix[r*NC + c]) return;
    kill = 1'b1;
  endtask

  task automatic do_hit(input int x, input int y, input int ready_delay, input bit fs_at_hs);
    bit exp_kill;
    int er, ec, n;
    bit got, saw;
    predict(x, y, exp_kill, er, ec);
    scan_x = 16'(x);
    scan_y = 16'(y);
    alien_pixel = 1'b1;
    bullet_pixel = 1'b1;
    kill_ready = 1'b0;
    step();
    alien_pixel = 1'b0;
    bullet_pixel = 1'b0;
    if (exp_kill) begin
      n = 0;
      got = 1'b0;
      while (n < 20 && !got) begin
        // Overlaps and ready pulses while busy must have no effect.
        alien_pixel  = 1'($urandom);
        bullet_pixel = 1'($urandom);
        kill_ready   = 1'($urandom);
        scan_x       = 16'($urandom);
        step();
        n++;
        if (kill_valid) got = 1'b1;
      end
      check_eq("latency", n, er + ec + 3);
      if (!got) begin
        alien_pixel = 1'b0;
        bullet_pixel = 1'b0;
        return;
      end
      check_eq("busy_req", busy, 1);
      check_eq("kill_row", kill_row, er);
      check_eq("kill_col", kill_col, ec);
      kill_ready = 1'b0;
      for (int i = 0; i < ready_delay; i++) begin
        alien_pixel  = 1'($urandom);
        bullet_pixel = 1'($urandom);
        step();
        check_eq("hold_valid", kill_valid, 1);
        check_eq("hold_row", kill_row, er);
        check_eq("hold_col", kill_col, ec);
        check_eq("no_early_consume", bullet_consume, 0);
      end
      alien_pixel  = 1'b0;
      bullet_pixel = 1'b0;
      kill_ready   = 1'b1;
      frame_start  = fs_at_hs;
      step();
      kill_ready  = 1'b0;
      frame_start = 1'b0;
      score_m = score_m + RP * (NR - er);
      if (score_m > 65535) score_m = 65535;
      hit_frame_m = 1'b1;
      check_eq("valid_drop", kill_valid, 0);
      check_eq("consume", bullet_consume, 1);
      check_eq("score", score, score_m);
      step();
      check_eq("consume_once", bullet_consume, 0);
      check_eq("busy_idle", busy, 0);
    end else begin
      saw = 1'b0;
      for (int i = 0; i < 12; i++) begin
        kill_ready = 1'($urandom);
        step();
        if (kill_valid || bullet_consume) saw = 1'b1;
      end
      kill_ready = 1'b0;
      check_eq("no_kill", saw, 0);
      check_eq("busy_after_discard", busy, 0);
      check_eq("score_kept", score, score_m);
    end
    $display("hit (%0d,%0d) origin (%0d,%0d) kill=%0b row=%0d col=%0d score=%0d",
             x, y, formation_x, formation_y, exp_kill, er, ec, score);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    score_m = 0;
    hit_frame_m = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ox, oy, sx, sy;
    scan_x = '0; scan_y = '0; frame_start = 1'b0; alien_pixel = 1'b0;
    bullet_pixel = 1'b0; kill_ready = 1'b0; formation_x = 16'd50;
    formation_y = 16'd50; alive_matrix = 8'hFF; rst = 1'b0;

    do_reset();
    check_eq("rst_valid", kill_valid, 0);
    check_eq("rst_consume", bullet_consume, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_row", kill_row, 0);
    check_eq("rst_col", kill_col, 0);

    // Directed scenarios
    new_frame();
    do_hit(135, 95, 0, 1'b0);            // (1,2), +10
    new_frame();
    do_hit(82, 60, 0, 1'b0);             // x gap
    alive_matrix = 8'hFE;
    do_hit(55, 55, 0, 1'b0);             // dead alien
    alive_matrix = 8'hFF;
    do_hit(55, 55, 0, 1'b0);             // (0,0), +20
    new_frame();
    do_hit(100, 100, 10, 1'b0);          // stalled consumer
    do_hit(135, 95, 0, 1'b0);            // same frame: ignored
    new_frame();
    do_hit(55, 95, 2, 1'b1);             // frame_start at handshake
    do_hit(55, 55, 0, 1'b0);             // still locked
    new_frame();
    do_hit(215, 55, 0, 1'b0);            // beyond last column
    do_hit(55, 135, 0, 1'b0);            // beyond last row

    // Reset while a request is pending
    scan_x = 16'd55; scan_y = 16'd55;
    alien_pixel = 1'b1; bullet_pixel = 1'b1; kill_ready = 1'b0;
    step();
    alien_pixel = 1'b0; bullet_pixel = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("req_before_rst", kill_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    score_m = 0;
    hit_frame_m = 1'b0;
    check_eq("rst_mid_valid", kill_valid, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_score", score, 0);
    check_eq("rst_mid_row", kill_row, 0);
    check_eq("rst_mid_col", kill_col, 0);
    step();
    check_eq("rst_mid_consume", bullet_consume, 0);
    $display("reset during request: valid=%0b busy=%0b score=%0d", kill_valid, busy, score);
    do_hit(10, 10, 0, 1'b0);             // left of / above origin

    // Randomized
    for (int t = 0; t < 300; t++) begin
      ox = $urandom_range(20, 200);
      oy = $urandom_range(20, 200);
      formation_x  = 16'(ox);
      formation_y  = 16'(oy);
      alive_matrix = 8'($urandom);
      if ($urandom_range(0, 3) != 0) new_frame();
      sx = ox - 15 + $urandom_range(0, 190);
      sy = oy - 15 + $urandom_range(0, 100);
      do_hit(sx, sy, $urandom_range(0, 3), 1'($urandom_range(0, 5) == 0));
    end

    // Score saturation
    do_reset();
    formation_x  = 16'd50;
    formation_y  = 16'd50;
    alive_matrix = 8'hFF;
    while (score_m < 65520) begin
      new_frame();
      do_hit(55, 55, 0, 1'b0);
      if (errors > 20) break;
    end
    new_frame();
    do_hit(55, 95, 0, 1'b0);             // 65530
    new_frame();
    do_hit(55, 55, 0, 1'b0);             // saturates
    check_eq("score_sat", score, 16'hFFFF);
    new_frame();
    do_hit(55, 95, 0, 1'b0);             // stays saturated

    $display("Simulation finished: %0d checks, %0d errors", checks_total, errors);
    $finish;
  end

endmodule
